pc_seq: RTL

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq_pkg.sv | 28 ++
 rtl/pc_seq_if.sv | 29 ++
 rtl/pc_seq_npc_calc.sv | 26 ++
 rtl/pc_seq.sv | 118 +++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC selects and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pc_seq_pkg;

    // Next-PC select encodings driven by decode/execute
    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_ABSJMP = 2'b01;
    localparam logic [1:0] NPC_JMP    = 2'b10;
    localparam logic [1:0] NPC_RSVD   = 2'b11;

    // Sequential step between instructions
    localparam logic [31:0] PC_STEP = 32'd4;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_TRAP   = 2'd3
    } state_t;

    // A PC-relative target is used for ABSJMP, or JMP when the branch is taken
    function automatic logic is_taken(input logic [1:0] op, input logic br);
        return (op == NPC_ABSJMP) || ((op == NPC_JMP) && br);
    endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Fetch handshake and decode-control bundle between the PC sequencer and the pipeline.
// Latency: n/a (wires only).
// Backpressure: fetch held by withholding if_ack; decode held by stall or by withholding ctrl_valid.
interface pc_seq_if;
    import pc_seq_pkg::*;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic        inst_valid;
    logic        ctrl_valid;
    logic [1:0]  npc_op;
    logic        br;
    logic [31:0] offset;
    logic        stall;

    // Sequencer side
    modport master (
        output if_req, if_addr, inst_valid,
        input  if_ack, ctrl_valid, npc_op, br, offset, stall
    );

    // Memory / decode side
    modport slave (
        input  if_req, if_addr, inst_valid,
        output if_ack, ctrl_valid, npc_op, br, offset, stall
    );

endinterface

// File: rtl/pc_seq_npc_calc.sv
// Next-PC arithmetic: pc+4, pc+offset and the taken decision, all modulo 2^32.
// Latency: purely combinational.
// Backpressure: none.
module npc_calc
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] offset,
    input  logic        br,
    input  logic [1:0]  npc_op,
    output logic [31:0] npc,
    output logic [31:0] pc4,
    output logic        taken
);

    logic [31:0] target;

    // Both candidate addresses are computed every cycle; 32-bit adds wrap naturally
    always_comb begin
        pc4    = pc + PC_STEP;
        target = pc + offset;
        taken  = is_taken(npc_op, br);
        npc    = taken ? target : pc4;
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: BOOT -> FETCH -> DECODE loop, optional misaligned-target trap (PC_MISALIGN_TRAP_EN).
// Latency: 2 cycles minimum per instruction (fetch with same-cycle ack, decode with same-cycle control).
// Backpressure: FETCH waits for if_ack; DECODE holds while stall=1 or ctrl_valid=0.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    pc_seq_if.master     bus,
    output logic [31:0]  pc,
    output logic [31:0]  pc4,
    output logic [31:0]  retired,
    output logic         trap,
    output logic [31:0]  trap_addr
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] npc;
    logic        taken;
    logic        accept;     // control accepted in DECODE this cycle
    logic        trap_take;  // accepted control redirects to a misaligned target
    logic        commit;     // pc/retired advance this cycle
    logic [31:0] npc_next;   // address actually loaded into pc

    npc_calc u_npc_calc (
        .pc     (pc),
        .offset (bus.offset),
        .br     (bus.br),
        .npc_op (bus.npc_op),
        .npc    (npc),
        .pc4    (pc4),
        .taken  (taken)
    );

    assign bus.if_addr = pc;

`ifdef PC_MISALIGN_TRAP_EN
    assign trap_take = accept && taken && (npc[1:0] != 2'b00);
    assign npc_next  = npc;
`else
    // Without trapping, a misaligned target is silently word-aligned
    assign trap_take = 1'b0;
    assign npc_next  = taken ? {npc[31:2], 2'b00} : npc;
`endif

    assign commit = accept && !trap_take;

    // Next-state and handshake outputs for the sequencer FSM
    always_comb begin
        state_nxt      = state;
        bus.if_req     = 1'b0;
        bus.inst_valid = 1'b0;
        accept         = 1'b0;
        case (state)
            ST_BOOT: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                bus.if_req = 1'b1;
                if (bus.if_ack) begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                bus.inst_valid = 1'b1;
                // stall takes precedence over a valid control word
                if (bus.ctrl_valid && !bus.stall) begin
                    accept    = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_TRAP: begin
                state_nxt = ST_TRAP;
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
        if (trap_take) begin
            state_nxt = ST_TRAP;
        end
    end

    // State, pc and retired-count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_BOOT;
            pc      <= RESET_PC;
            retired <= 32'd0;
        end else begin
            state <= state_nxt;
            if (commit) begin
                pc      <= npc_next;
                retired <= retired + 32'd1;
            end
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // Sticky trap flag and faulting target, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            trap      <= 1'b0;
            trap_addr <= 32'd0;
        end else if (trap_take) begin
            trap      <= 1'b1;
            trap_addr <= npc;
        end
    end
`else
    assign trap      = 1'b0;
    assign trap_addr = 32'd0;
`endif

endmodule
